// File: rtl/exe_pkg.sv
// exe_pkg: shared types and constants for the execute stage.
// Holds the ALU op encoding, the multiply/divide FSM states, the jump-and-link
// code and the divide-by-zero quotient.
package exe_pkg;
    localparam int DATA_W   = 32;
    localparam int MD_ITERS = 32;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MULT, OP_DIV, OP_MFHI, OP_MFLO
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    localparam logic [1:0]  JUMP_LINK = 2'b10;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
endpackage

// File: rtl/exe_md_unit.sv
// md_unit: iterative signed multiply/divide with HI/LO registers.
// Ports: clk, rst_b (async active-low); i_op/i_halted/i_val1/i_val2 from the
// held EXE instruction; o_busy stall request; o_hi/o_lo current HI/LO.
// EXE_FAST_MUL_EN: when defined, MULT is a one-cycle combinational product.
module md_unit import exe_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int MD_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  alu_op_t           i_op,
    input  logic              i_halted,
    input  logic [DATA_W-1:0] i_val1,
    input  logic [DATA_W-1:0] i_val2,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);
    localparam int CW = $clog2(MD_ITERS);

    md_state_t             r_state, w_state_nx;
    logic [CW-1:0]         r_cnt;
    logic [DATA_W-1:0]     r_m;
    logic [2*DATA_W-1:0]   r_acc;
    logic                  r_is_div, r_neg_q, r_neg_r;
    logic [DATA_W-1:0]     r_hi, r_lo;

    logic                  w_start, w_last, w_s1, w_s2, w_div;
    logic [DATA_W-1:0]     w_abs1, w_abs2, w_quo, w_rem, w_hi_fin, w_lo_fin;
    logic [DATA_W:0]       w_add, w_rs, w_diff;
    logic [2*DATA_W-1:0]   w_mul_nx, w_div_nx, w_acc_nx, w_prod;

`ifdef EXE_FAST_MUL_EN
    logic                  w_fast;
    logic [2*DATA_W-1:0]   w_fprod;
    assign w_start = !i_halted && i_op == OP_DIV;
    assign w_fast  = !i_halted && i_op == OP_MULT;
    assign w_fprod = $signed(i_val1) * $signed(i_val2);
`else
    assign w_start = !i_halted && (i_op == OP_MULT || i_op == OP_DIV);
`endif

    assign w_div  = i_op == OP_DIV;
    assign w_s1   = i_val1[DATA_W-1];
    assign w_s2   = i_val2[DATA_W-1];
    assign w_abs1 = w_s1 ? -i_val1 : i_val1;
    assign w_abs2 = w_s2 ? -i_val2 : i_val2;
    assign w_last = r_cnt == CW'(MD_ITERS - 1);

    // Multiply: r_acc = {partial sum, remaining multiplier bits}; add r_m on LSB, shift right.
    assign w_add    = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_nx = {w_add, r_acc[DATA_W-1:1]};
    // Divide: r_acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
    assign w_rs     = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_diff   = w_rs - {1'b0, r_m};
    assign w_div_nx = w_diff[DATA_W] ? {w_rs[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                                     : {w_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
    assign w_acc_nx = r_is_div ? w_div_nx : w_mul_nx;

    // Sign fix-up; a zero divisor naturally leaves |dividend| as remainder, which
    // re-signs back to the dividend, so only the quotient needs overriding.
    assign w_prod   = r_neg_q ? -w_acc_nx : w_acc_nx;
    assign w_quo    = w_acc_nx[DATA_W-1:0];
    assign w_rem    = w_acc_nx[2*DATA_W-1:DATA_W];
    assign w_hi_fin = r_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[2*DATA_W-1:DATA_W];
    assign w_lo_fin = r_is_div ? ((r_m == '0) ? DIV0_QUOT : (r_neg_q ? -w_quo : w_quo))
                               : w_prod[DATA_W-1:0];

    always_comb begin
        w_state_nx = r_state;
        o_busy     = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy     = w_start;
                w_state_nx = w_start ? BUSY : IDLE;
            end
            BUSY: begin
                o_busy     = 1'b1;
                w_state_nx = w_last ? DONE : BUSY;
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == IDLE && w_start) begin
                r_cnt    <= '0;
                r_is_div <= w_div;
                r_m      <= w_div ? w_abs2 : w_abs1;
                r_acc    <= {{DATA_W{1'b0}}, (w_div ? w_abs1 : w_abs2)};
                r_neg_q  <= w_s1 ^ w_s2;
                r_neg_r  <= w_s1;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_acc_nx;
                if (w_last) begin
                    r_hi <= w_hi_fin;
                    r_lo <= w_lo_fin;
                end
            end
`ifdef EXE_FAST_MUL_EN
            else if (r_state == IDLE && w_fast) begin
                r_hi <= w_fprod[2*DATA_W-1:DATA_W];
                r_lo <= w_fprod[DATA_W-1:0];
            end
`endif
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage - ALU, jump-link mux, mul/div unit and bubble gating.
// Ports: clk, rst_b (async active-low); i_val1/i_val2 operands, i_control ALU op,
// decode control bits and pass-through fields in; o_alu_result plus gated/passed
// control out; o_exe_busy freezes upstream while the mul/div unit works.
// EXE_FAST_MUL_EN: when defined, MULT completes in one cycle without stalling.
module exe_stage import exe_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int MD_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [DATA_W-1:0] i_val1,
    input  logic [DATA_W-1:0] i_val2,
    input  logic [DATA_W-1:0] i_saved_val,
    input  logic [3:0]        i_control,
    input  logic              i_mem_write,
    input  logic              i_is_LB_SB,
    input  logic              i_is_SW_SB,
    input  logic              i_cache_en,
    input  logic              i_mem_to_reg,
    input  logic              i_reg_write,
    input  logic              i_halted,
    input  logic [1:0]        i_jump,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [4:0]        i_dest_reg_num,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [DATA_W-1:0] o_saved_val_out,
    output logic [4:0]        o_dest_reg_num_out,
    output logic [DATA_W-1:0] o_pc_out,
    output logic              o_mem_write_out,
    output logic              o_is_LB_SB_out,
    output logic              o_is_SW_SB_out,
    output logic              o_cache_en_out,
    output logic              o_mem_to_reg_out,
    output logic              o_reg_write_out,
    output logic              o_halted_out,
    output logic              o_exe_busy
);
    alu_op_t           w_op;
    logic              w_busy;
    logic [DATA_W-1:0] w_hi, w_lo, w_alu;
    logic [4:0]        w_sh;

    assign w_op = alu_op_t'(i_control);
    assign w_sh = i_val2[4:0];

    md_unit #(.DATA_W(DATA_W), .MD_ITERS(MD_ITERS)) u_md (
        .clk      (clk),
        .rst_b    (rst_b),
        .i_op     (w_op),
        .i_halted (i_halted),
        .i_val1   (i_val1),
        .i_val2   (i_val2),
        .o_busy   (w_busy),
        .o_hi     (w_hi),
        .o_lo     (w_lo)
    );

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = i_val1 + i_val2;
            OP_SUB:  w_alu = i_val1 - i_val2;
            OP_AND:  w_alu = i_val1 & i_val2;
            OP_OR:   w_alu = i_val1 | i_val2;
            OP_XOR:  w_alu = i_val1 ^ i_val2;
            OP_NOR:  w_alu = ~(i_val1 | i_val2);
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, $signed(i_val1) < $signed(i_val2)};
            OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, i_val1 < i_val2};
            OP_SLL:  w_alu = i_val1 << w_sh;
            OP_SRL:  w_alu = i_val1 >> w_sh;
            OP_SRA:  w_alu = $signed(i_val1) >>> w_sh;
            OP_LUI:  w_alu = {i_val2[15:0], {(DATA_W-16){1'b0}}};
            OP_MFHI: w_alu = w_hi;
            OP_MFLO: w_alu = w_lo;
            default: w_alu = '0;
        endcase
    end

    assign o_alu_result       = (i_jump == JUMP_LINK) ? i_pc + DATA_W'(4) : w_alu;
    assign o_exe_busy         = w_busy;
    assign o_saved_val_out    = i_saved_val;
    assign o_dest_reg_num_out = i_dest_reg_num;
    assign o_pc_out           = i_pc;
    assign o_is_LB_SB_out     = i_is_LB_SB;
    assign o_is_SW_SB_out     = i_is_SW_SB;
    assign o_mem_to_reg_out   = i_mem_to_reg;
    // Bubble: side-effecting controls are suppressed while the instruction is held.
    assign o_mem_write_out    = i_mem_write & ~w_busy;
    assign o_cache_en_out     = i_cache_en & ~w_busy;
    assign o_reg_write_out    = i_reg_write & ~w_busy;
    assign o_halted_out       = i_halted & ~w_busy;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage (default build, iterative MULT).
module tb_exe_stage;
    import exe_pkg::*;

    logic        clk = 1'b0, rst_b = 1'b0;
    logic [31:0] i_val1 = '0, i_val2 = '0, i_saved_val = '0, i_pc = '0;
    logic [3:0]  i_control = '0;
    logic        i_mem_write = 1'b0, i_is_LB_SB = 1'b0, i_is_SW_SB = 1'b0, i_cache_en = 1'b0;
    logic        i_mem_to_reg = 1'b0, i_reg_write = 1'b0, i_halted = 1'b0;
    logic [1:0]  i_jump = '0;
    logic [4:0]  i_dest_reg_num = '0;
    logic [31:0] o_alu_result, o_saved_val_out, o_pc_out;
    logic [4:0]  o_dest_reg_num_out;
    logic        o_mem_write_out, o_is_LB_SB_out, o_is_SW_SB_out, o_cache_en_out;
    logic        o_mem_to_reg_out, o_reg_write_out, o_halted_out, o_exe_busy;

    exe_stage dut (
        .clk(clk), .rst_b(rst_b),
        .i_val1(i_val1), .i_val2(i_val2), .i_saved_val(i_saved_val), .i_control(i_control),
        .i_mem_write(i_mem_write), .i_is_LB_SB(i_is_LB_SB), .i_is_SW_SB(i_is_SW_SB),
        .i_cache_en(i_cache_en), .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write),
        .i_halted(i_halted), .i_jump(i_jump), .i_pc(i_pc), .i_dest_reg_num(i_dest_reg_num),
        .o_alu_result(o_alu_result), .o_saved_val_out(o_saved_val_out),
        .o_dest_reg_num_out(o_dest_reg_num_out), .o_pc_out(o_pc_out),
        .o_mem_write_out(o_mem_write_out), .o_is_LB_SB_out(o_is_LB_SB_out),
        .o_is_SW_SB_out(o_is_SW_SB_out), .o_cache_en_out(o_cache_en_out),
        .o_mem_to_reg_out(o_mem_to_reg_out), .o_reg_write_out(o_reg_write_out),
        .o_halted_out(o_halted_out), .o_exe_busy(o_exe_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        chk_res;
        int          stall;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0, stall = 0;
    logic tb_valid = 1'b0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: counts stall cycles, checks bubbles, pops on the cycle the instruction leaves.
    always @(negedge clk) begin
        if (tb_valid && rst_b) begin
            if (o_exe_busy) begin
                stall++;
                chk("bubble", {28'd0, o_reg_write_out, o_mem_write_out, o_cache_en_out, o_halted_out}, 32'd0);
            end else if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_res) chk({e.name, "_res"}, o_alu_result, e.res);
                chk({e.name, "_stall"}, stall, e.stall);
                chk({e.name, "_rw"}, {31'd0, o_reg_write_out}, 32'd1);
                chk({e.name, "_halt"}, {31'd0, o_halted_out}, {31'd0, e.halted});
                stall = 0;
            end
        end
    end

    task automatic issue(input string n, input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic cr, input int st,
                         input logic h = 1'b0, input logic [1:0] j = 2'b00, input logic [31:0] p = 32'h0);
        exp_t e;
        bit   done;
        e.name = n; e.res = exp; e.chk_res = cr; e.stall = st; e.halted = h;
        sb.push_back(e);
        i_control = op; i_val1 = a; i_val2 = b; i_halted = h; i_jump = j; i_pc = p;
        i_reg_write = 1'b1; i_cache_en = 1'b1; i_mem_write = 1'b1;
        tb_valid = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = !o_exe_busy;
        end
        if (!done) chk({"timeout_", n}, 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_busy", {31'd0, o_exe_busy}, 32'd0);
        chk("rst_res", o_alu_result, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk);
        #1;

        issue("ADD",  OP_ADD,  32'd5, 32'd7, 32'd12, 1'b1, 0);
        issue("SUB",  OP_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        issue("AND",  OP_AND,  32'hF0F0, 32'hFF00, 32'hF000, 1'b1, 0);
        issue("OR",   OP_OR,   32'h0F, 32'hF0, 32'hFF, 1'b1, 0);
        issue("XOR",  OP_XOR,  32'hFF, 32'h0F, 32'hF0, 1'b1, 0);
        issue("NOR",  OP_NOR,  32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 0);
        issue("SLT",  OP_SLT,  32'hFFFF_FFFF, 32'h0, 32'd1, 1'b1, 0);
        issue("SLTU", OP_SLTU, 32'hFFFF_FFFF, 32'h0, 32'd0, 1'b1, 0);
        issue("SLL",  OP_SLL,  32'h1, 32'h23, 32'h8, 1'b1, 0);
        issue("SRL",  OP_SRL,  32'h8000_0000, 32'h4, 32'h0800_0000, 1'b1, 0);
        issue("SRA",  OP_SRA,  32'h8000_0000, 32'h4, 32'hF800_0000, 1'b1, 0);
        issue("LUI",  OP_LUI,  32'h0, 32'hABCD_1234, 32'h1234_0000, 1'b1, 0);
        issue("LINK", OP_ADD,  32'd1, 32'd2, 32'h104, 1'b1, 0, 1'b0, 2'b10, 32'h100);

        issue("MULT1", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'h0, 1'b0, 33);
        issue("MFLO1", OP_MFLO, 32'h0, 32'h0, 32'hFFFF_FFEB, 1'b1, 0);
        issue("MFHI1", OP_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 0);
        issue("MULT2", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0, 33);
        issue("MFHI2", OP_MFHI, 32'h0, 32'h0, 32'h4000_0000, 1'b1, 0);
        issue("MFLO2", OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b1, 0);
        issue("MULT3", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
        issue("MFHI3", OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b1, 0);
        issue("MFLO3", OP_MFLO, 32'h0, 32'h0, 32'h1, 1'b1, 0);

        issue("DIV1",  OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'h0, 1'b0, 33);
        issue("MFLO4", OP_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFD, 1'b1, 0);
        issue("MFHI4", OP_MFHI, 32'h0, 32'h0, 32'h1, 1'b1, 0);
        issue("DIV2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 33);
        issue("MFLO5", OP_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFD, 1'b1, 0);
        issue("MFHI5", OP_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 0);
        issue("DIV0",  OP_DIV,  32'd9, 32'd0, 32'h0, 1'b0, 33);
        issue("MFLO6", OP_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 0);
        issue("MFHI6", OP_MFHI, 32'h0, 32'h0, 32'd9, 1'b1, 0);
        issue("DIVOV", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
        issue("MFLO7", OP_MFLO, 32'h0, 32'h0, 32'h8000_0000, 1'b1, 0);
        issue("MFHI7", OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b1, 0);

        issue("MULTH", OP_MULT, 32'd5, 32'd5, 32'h0, 1'b0, 0, 1'b1);
        issue("MFLO8", OP_MFLO, 32'h0, 32'h0, 32'h8000_0000, 1'b1, 0);
        issue("MFHI8", OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b1, 0);

        // Reset in the middle of a MULT; upstream registers reset together with EXE.
        i_control = OP_MULT; i_val1 = 32'd6; i_val2 = 32'd7; i_halted = 1'b0; i_jump = 2'b00;
        tb_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, o_exe_busy}, 32'd1);
        rst_b = 1'b0;
        tb_valid = 1'b0;
        i_control = '0; i_val1 = '0; i_val2 = '0; i_reg_write = 1'b0; i_cache_en = 1'b0; i_mem_write = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, o_exe_busy}, 32'd0);
        chk("midrst_res", o_alu_result, 32'd0);
        stall = 0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk);
        #1;
        issue("MFLO9", OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b1, 0);
        issue("MFHI9", OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b1, 0);
        issue("ADD2",  OP_ADD,  32'd5, 32'd7, 32'd12, 1'b1, 0);

        tb_valid = 1'b0;
        @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
